// File: rtl/draw_scheduler.sv
// Walks a triangle list in vertex RAM, feeds three vertices at a time into the draw
// datapath and presents settled screen-space triangles. Optional culling: DRAW_BACKFACE_CULL_EN.
module draw_scheduler #(
    parameter int TRI_W    = 10,
    parameter int ADDR_W   = 12,
    parameter int DRAW_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [TRI_W-1:0]  tri_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] vtx_addr,
    output logic              vtx_rd,
    input  logic [63:0]       vtx_data,
    output logic [63:0]       vertex_a,
    output logic [63:0]       vertex_b,
    output logic [63:0]       vertex_c,
    input  logic [31:0]       draw_v1,
    input  logic [31:0]       draw_v2,
    input  logic [31:0]       draw_v3,
    output logic              tri_valid,
    input  logic              tri_ready,
    output logic [31:0]       tri_v1,
    output logic [31:0]       tri_v2,
    output logic [31:0]       tri_v3,
    output logic [TRI_W-1:0]  tri_index,
`ifdef DRAW_BACKFACE_CULL_EN
    output logic [TRI_W-1:0]  culled_cnt,
`endif
    output logic [3:0]        state_o
);

    localparam int CNT_W = (DRAW_LAT > 1) ? $clog2(DRAW_LAT) : 1;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RD_A    = 4'd1,
        S_RD_B    = 4'd2,
        S_RD_C    = 4'd3,
        S_CAP_C   = 4'd4,
        S_SETTLE  = 4'd5,
        S_CULL    = 4'd6,
        S_PRESENT = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    state_t            state_q, state_d;
    logic [TRI_W-1:0]  count_q, count_d;
    logic [TRI_W-1:0]  idx_q, idx_d;
    logic [TRI_W-1:0]  tri_index_q, tri_index_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  settle_q, settle_d;
    logic [63:0]       vertex_a_q, vertex_a_d;
    logic [63:0]       vertex_b_q, vertex_b_d;
    logic [63:0]       vertex_c_q, vertex_c_d;
    logic [31:0]       tri_v1_q, tri_v1_d;
    logic [31:0]       tri_v2_q, tri_v2_d;
    logic [31:0]       tri_v3_q, tri_v3_d;
    logic              last_tri;
    logic              advance;

    assign last_tri = (idx_q == count_q - TRI_W'(1));

`ifdef DRAW_BACKFACE_CULL_EN
    logic [TRI_W-1:0]   culled_q, culled_d;
    logic signed [16:0] dx21, dy31, dy21, dx31;
    logic signed [33:0] prod_a, prod_b;
    logic signed [34:0] area;

    // Full-precision signed area of the latched screen triangle; positive means CCW.
    always_comb begin
        dx21   = 17'($signed(tri_v2_q[15:0]))  - 17'($signed(tri_v1_q[15:0]));
        dy31   = 17'($signed(tri_v3_q[31:16])) - 17'($signed(tri_v1_q[31:16]));
        dy21   = 17'($signed(tri_v2_q[31:16])) - 17'($signed(tri_v1_q[31:16]));
        dx31   = 17'($signed(tri_v3_q[15:0]))  - 17'($signed(tri_v1_q[15:0]));
        prod_a = 34'(dx21) * 34'(dy31);
        prod_b = 34'(dy21) * 34'(dx31);
        area   = 35'(prod_a) - 35'(prod_b);
    end

    always_ff @(posedge Clk) begin
        if (Reset) culled_q <= '0;
        else       culled_q <= culled_d;
    end

    assign culled_cnt = culled_q;
`endif

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        tri_index_d = tri_index_q;
        base_d      = base_q;
        settle_d    = settle_q;
        vertex_a_d  = vertex_a_q;
        vertex_b_d  = vertex_b_q;
        vertex_c_d  = vertex_c_q;
        tri_v1_d    = tri_v1_q;
        tri_v2_d    = tri_v2_q;
        tri_v3_d    = tri_v3_q;
        advance     = 1'b0;
`ifdef DRAW_BACKFACE_CULL_EN
        culled_d    = culled_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d = tri_count;
                    idx_d   = '0;
                    base_d  = '0;
`ifdef DRAW_BACKFACE_CULL_EN
                    culled_d = '0;
`endif
                    state_d = (tri_count == '0) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A: state_d = S_RD_B;
            // RAM data lags the address by one cycle, so each capture trails its read.
            S_RD_B: begin
                vertex_a_d = vtx_data;
                state_d    = S_RD_C;
            end
            S_RD_C: begin
                vertex_b_d = vtx_data;
                state_d    = S_CAP_C;
            end
            S_CAP_C: begin
                vertex_c_d = vtx_data;
                settle_d   = CNT_W'(DRAW_LAT - 1);
                state_d    = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    tri_v1_d    = draw_v1;
                    tri_v2_d    = draw_v2;
                    tri_v3_d    = draw_v3;
                    tri_index_d = idx_q;
`ifdef DRAW_BACKFACE_CULL_EN
                    state_d     = S_CULL;
`else
                    state_d     = S_PRESENT;
`endif
                end else begin
                    settle_d = settle_q - CNT_W'(1);
                end
            end
`ifdef DRAW_BACKFACE_CULL_EN
            S_CULL: begin
                if (area > 0) begin
                    state_d = S_PRESENT;
                end else begin
                    culled_d = culled_q + TRI_W'(1);
                    advance  = 1'b1;
                end
            end
`endif
            // tri_valid is high for the whole PRESENT state; a transfer happens on any
            // cycle where tri_valid and tri_ready are both high, and outputs hold until then.
            S_PRESENT: begin
                if (tri_ready) advance = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            idx_d   = idx_q + TRI_W'(1);
            base_d  = base_q + ADDR_W'(3);
            state_d = last_tri ? S_DONE : S_RD_A;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            tri_index_q <= '0;
            base_q      <= '0;
            settle_q    <= '0;
            vertex_a_q  <= '0;
            vertex_b_q  <= '0;
            vertex_c_q  <= '0;
            tri_v1_q    <= '0;
            tri_v2_q    <= '0;
            tri_v3_q    <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            tri_index_q <= tri_index_d;
            base_q      <= base_d;
            settle_q    <= settle_d;
            vertex_a_q  <= vertex_a_d;
            vertex_b_q  <= vertex_b_d;
            vertex_c_q  <= vertex_c_d;
            tri_v1_q    <= tri_v1_d;
            tri_v2_q    <= tri_v2_d;
            tri_v3_q    <= tri_v3_d;
        end
    end

    always_comb begin
        vtx_addr = '0;
        case (state_q)
            S_RD_A:  vtx_addr = base_q;
            S_RD_B:  vtx_addr = base_q + ADDR_W'(1);
            S_RD_C:  vtx_addr = base_q + ADDR_W'(2);
            default: vtx_addr = '0;
        endcase
    end

    assign vtx_rd    = (state_q == S_RD_A) || (state_q == S_RD_B) || (state_q == S_RD_C);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign tri_valid = (state_q == S_PRESENT);
    assign vertex_a  = vertex_a_q;
    assign vertex_b  = vertex_b_q;
    assign vertex_c  = vertex_c_q;
    assign tri_v1    = tri_v1_q;
    assign tri_v2    = tri_v2_q;
    assign tri_v3    = tri_v3_q;
    assign tri_index = tri_index_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: RAM model, one-cycle draw echo stub, table-driven passes
// with a scoreboard of expected triangles, plus reset and culling sequences.
module tb_draw_scheduler;

    localparam int TRI_W    = 10;
    localparam int ADDR_W   = 12;
    localparam int DRAW_LAT = 2;
    localparam int EXP_W    = TRI_W + 96;
`ifdef DRAW_BACKFACE_CULL_EN
    localparam int CULL_ADD = 1;
`else
    localparam int CULL_ADD = 0;
`endif
    localparam int T = 5 + DRAW_LAT + CULL_ADD;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              start = 1'b0;
    logic [TRI_W-1:0]  tri_count = '0;
    logic              busy, done, vtx_rd, tri_valid;
    logic              tri_ready = 1'b0;
    logic [ADDR_W-1:0] vtx_addr;
    logic [63:0]       vtx_data = '0;
    logic [63:0]       vertex_a, vertex_b, vertex_c;
    logic [31:0]       draw_v1 = '0, draw_v2 = '0, draw_v3 = '0;
    logic [31:0]       tri_v1, tri_v2, tri_v3;
    logic [TRI_W-1:0]  tri_index;
    logic [3:0]        state_o;
`ifdef DRAW_BACKFACE_CULL_EN
    logic [TRI_W-1:0]  culled_cnt;
`endif

    logic [63:0]      mem [0:(1<<ADDR_W)-1];
    logic [EXP_W-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    typedef struct {
        int n;
        int stall_tri;
        int stall_cyc;
        int poke;
        int exp_done;
        int exp_hs;
    } vec_t;
    vec_t vecs [6];

    draw_scheduler #(.TRI_W(TRI_W), .ADDR_W(ADDR_W), .DRAW_LAT(DRAW_LAT)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .tri_count(tri_count),
        .busy(busy), .done(done), .vtx_addr(vtx_addr), .vtx_rd(vtx_rd),
        .vtx_data(vtx_data), .vertex_a(vertex_a), .vertex_b(vertex_b),
        .vertex_c(vertex_c), .draw_v1(draw_v1), .draw_v2(draw_v2),
        .draw_v3(draw_v3), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_v1(tri_v1), .tri_v2(tri_v2), .tri_v3(tri_v3), .tri_index(tri_index),
`ifdef DRAW_BACKFACE_CULL_EN
        .culled_cnt(culled_cnt),
`endif
        .state_o(state_o)
    );

    // Clock / reset-free models
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (vtx_rd) vtx_data <= mem[vtx_addr];
        draw_v1 <= vertex_a[31:0];
        draw_v2 <= vertex_b[31:0];
        draw_v3 <= vertex_c[31:0];
    end

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, {busy, done, vtx_rd, vtx_addr, vertex_a, vertex_b, vertex_c,
                     tri_valid, tri_v1, tri_v2, tri_v3, tri_index}, '0);
        check({name, "_state"}, 320'(state_o), 320'(0));
    endtask

    task automatic put_tri(input int i, input logic [15:0] x1, input logic [15:0] y1,
                           input logic [15:0] x2, input logic [15:0] y2,
                           input logic [15:0] x3, input logic [15:0] y3, input bit push);
        logic [TRI_W-1:0] ti;
        ti = TRI_W'(i);
        mem[3*i]   = {16'h0100, 16'($urandom), y1, x1};
        mem[3*i+1] = {16'h0100, 16'($urandom), y2, x2};
        mem[3*i+2] = {16'h0100, 16'($urandom), y3, x3};
        if (push) exp_q.push_back({ti, y1, x1, y2, x2, y3, x3});
    endtask

    // Random counter-clockwise triangles so every one is presented in either build.
    task automatic fill_ccw(input int n);
        logic [15:0] x1, y1, dx, dy;
        for (int i = 0; i < n; i++) begin
            x1 = 16'($urandom_range(0, 16'h3fff)) - 16'h2000;
            y1 = 16'($urandom_range(0, 16'h3fff)) - 16'h2000;
            dx = 16'($urandom_range(1, 16'h1fff));
            dy = 16'($urandom_range(1, 16'h1fff));
            put_tri(i, x1, y1, x1 + dx, y1, x1, y1 + dy, 1'b1);
        end
    endtask

    task automatic run_pass(input int n, input int stall_tri, input int stall_cyc,
                            input int poke, input int exp_done, input int exp_hs,
                            input int exp_first_valid, input int exp_culled);
        int cyc, rd_cnt, hs, done_cyc, stalled, first_valid;
        bit busy_gap, have_snap;
        logic [319:0] cur, snap;
        logic [EXP_W-1:0] exp;
        cyc = 0; rd_cnt = 0; hs = 0; done_cyc = -1; stalled = 0; first_valid = -1;
        busy_gap = 0; have_snap = 0; snap = '0;
        @(negedge Clk);
        start = 1'b1;
        tri_count = TRI_W'(n);
        while (done_cyc < 0 && cyc < 3000) begin
            @(negedge Clk);
            cyc++;
            start = (cyc == poke);
            if (cyc == 1) tri_count = TRI_W'($urandom);
            if (!busy) busy_gap = 1;
            if (vtx_rd) begin
                check("vtx_addr", 320'(vtx_addr), 320'(rd_cnt));
                rd_cnt++;
            end
            if (tri_valid) begin
                if (first_valid < 0) first_valid = cyc;
                cur = 320'({tri_index, tri_v1, tri_v2, tri_v3, vertex_a, vertex_b, vertex_c});
                if (have_snap) check("hold", cur, snap);
                if (int'(tri_index) == stall_tri && stalled < stall_cyc) begin
                    tri_ready = 1'b0;
                    stalled++;
                    snap = cur;
                    have_snap = 1;
                end else begin
                    tri_ready = 1'b1;
                    have_snap = 0;
                    hs++;
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_tri", 320'(tri_index), '1);
                    end else begin
                        exp = exp_q.pop_front();
                        check("tri_out", 320'({tri_index, tri_v1, tri_v2, tri_v3}), 320'(exp));
                    end
                end
            end else begin
                tri_ready = 1'($urandom_range(0, 1));
            end
            if (done) done_cyc = cyc;
        end
        start = 1'b0;
        check("done_cycle", 320'(done_cyc), 320'(exp_done));
        check("busy_continuous", 320'(busy_gap), 320'(0));
        check("handshakes", 320'(hs), 320'(exp_hs));
        check("reads", 320'(rd_cnt), 320'(3 * n));
        check("first_valid", 320'(first_valid), 320'(exp_first_valid));
        check("sb_left", 320'(exp_q.size()), 320'(0));
`ifdef DRAW_BACKFACE_CULL_EN
        check("culled_cnt", 320'(culled_cnt), 320'(exp_culled));
`else
        if (exp_culled != 0) check("culled_arg", 320'(exp_culled), 320'(0));
`endif
        @(negedge Clk);
        check("done_drop", 320'({busy, done}), 320'(0));
        tri_ready = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{n:1, stall_tri:-1, stall_cyc:0, poke:0, exp_done:1+T,       exp_hs:1};
        vecs[1] = '{n:3, stall_tri:1,  stall_cyc:4, poke:0, exp_done:1+3*T+4,   exp_hs:3};
        vecs[2] = '{n:0, stall_tri:-1, stall_cyc:0, poke:0, exp_done:1,         exp_hs:0};
        vecs[3] = '{n:4, stall_tri:-1, stall_cyc:0, poke:3, exp_done:1+4*T,     exp_hs:4};
        vecs[4] = '{n:2, stall_tri:0,  stall_cyc:1, poke:9, exp_done:1+2*T+1,   exp_hs:2};
        vecs[5] = '{n:5, stall_tri:4,  stall_cyc:3, poke:0, exp_done:1+5*T+3,   exp_hs:5};

        repeat (3) @(negedge Clk);
        check_zero("reset_init");
        Reset = 1'b0;

        // Fixed triangle: (0x0380,0),(0,0x0233),(0x0566,0) is clockwise.
`ifdef DRAW_BACKFACE_CULL_EN
        put_tri(0, 16'h0380, 16'h0, 16'h0, 16'h0233, 16'h0566, 16'h0, 1'b0);
        run_pass(1, -1, 0, 0, 1 + 4 + DRAW_LAT + 1, 0, -1, 1);
`else
        put_tri(0, 16'h0380, 16'h0, 16'h0, 16'h0233, 16'h0566, 16'h0, 1'b1);
        run_pass(1, -1, 0, 0, 8, 1, 7, 0);
`endif

        for (int v = 0; v < 6; v++) begin
            fill_ccw(vecs[v].n);
            run_pass(vecs[v].n, vecs[v].stall_tri, vecs[v].stall_cyc, vecs[v].poke,
                     vecs[v].exp_done, vecs[v].exp_hs, (vecs[v].n > 0) ? T : -1, 0);
        end

        // Reset while fetching the second vertex, then a normal pass.
        fill_ccw(2);
        exp_q.delete();
        @(negedge Clk);
        start = 1'b1;
        tri_count = TRI_W'(2);
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
        check("rd_b_live", 320'({busy, vtx_rd, vtx_addr}), 320'({1'b1, 1'b1, 12'd1}));
        Reset = 1'b1;
        @(negedge Clk);
        check_zero("reset_mid");
        Reset = 1'b0;
        fill_ccw(2);
        run_pass(2, -1, 0, 0, 1 + 2 * T, 2, T, 0);

`ifdef DRAW_BACKFACE_CULL_EN
        put_tri(0, 16'h0, 16'h0, 16'h0A00, 16'h0, 16'h0, 16'h0A00, 1'b1);
        put_tri(1, 16'h0, 16'h0A00, 16'h0A00, 16'h0, 16'h0, 16'h0, 1'b0);
        put_tri(2, 16'h0, 16'h0, 16'h0100, 16'h0100, 16'h0200, 16'h0200, 1'b0);
        run_pass(3, -1, 0, 0, 1 + T + 2 * (T - 1), 1, T, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
